// File: rtl/uart_alu_interface.sv
// Command sequencer between the UART RX/TX FIFOs and the combinational ALU:
// pops A, B and opcode bytes, runs the ALU, pushes the result byte.
module uart_alu_interface #(
    parameter int NB_DATA  = 8,
    parameter int NB_OP    = 6,
    parameter int NB_COUNT = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_fiforx_EMPTY,
    input  logic [NB_DATA-1:0]  i_fiforx_READDATA,
    output logic                o_fiforx_READ,
    input  logic                i_fifotx_FULL,
    output logic                o_fifotx_WRITE,
    output logic [NB_DATA-1:0]  o_fifotx_WRITEDATA,
    output logic [NB_DATA-1:0]  o_alu_A,
    output logic [NB_DATA-1:0]  o_alu_B,
    output logic [NB_OP-1:0]    o_alu_OP,
    input  logic [NB_DATA-1:0]  i_alu_RESULT,
    output logic                o_busy,
    output logic [NB_COUNT-1:0] o_opcount,
    output logic [2:0]          o_state
);

    localparam logic [2:0] S_GET_A  = 3'd0;
    localparam logic [2:0] S_GET_B  = 3'd1;
    localparam logic [2:0] S_GET_OP = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_SEND   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [NB_DATA-1:0]  a_q, a_d;
    logic [NB_DATA-1:0]  b_q, b_d;
    logic [NB_OP-1:0]    op_q, op_d;
    logic [NB_DATA-1:0]  wdata_q, wdata_d;
    logic [NB_COUNT-1:0] count_q, count_d;
    logic                in_get;
    logic                rx_pop;
    logic                tx_push;

    // FIFO handshake: a byte moves at an edge where READ (WRITE) is high;
    // READ is only raised while EMPTY is low and WRITE only while FULL is low.
    assign in_get  = (state_q == S_GET_A) || (state_q == S_GET_B) || (state_q == S_GET_OP);
    assign rx_pop  = !i_reset && in_get && !i_fiforx_EMPTY;
    assign tx_push = !i_reset && (state_q == S_SEND) && !i_fifotx_FULL;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        count_d = count_q;
        case (state_q)
            S_GET_A: begin
                if (!i_fiforx_EMPTY) begin
                    a_d     = i_fiforx_READDATA;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (!i_fiforx_EMPTY) begin
                    b_d     = i_fiforx_READDATA;
                    state_d = S_GET_OP;
                end
            end
            S_GET_OP: begin
                if (!i_fiforx_EMPTY) begin
                    op_d    = i_fiforx_READDATA[NB_OP-1:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                wdata_d = i_alu_RESULT;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!i_fifotx_FULL) begin
                    count_d = count_q + NB_COUNT'(1);
                    state_d = S_GET_A;
                end
            end
            default: state_d = S_GET_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

    assign o_fiforx_READ      = rx_pop;
    assign o_fifotx_WRITE     = tx_push;
    assign o_fifotx_WRITEDATA = wdata_q;
    assign o_alu_A            = a_q;
    assign o_alu_B            = b_q;
    assign o_alu_OP           = op_q;
    assign o_busy             = (state_q != S_GET_A);
    assign o_opcount          = count_q;
    assign o_state            = state_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: queue-backed RX FIFO, stub ALU, and a
// scoreboard of expected result bytes derived from the command stream.
module tb_uart_alu_interface;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_fiforx_EMPTY;
    logic [7:0] i_fiforx_READDATA;
    logic       o_fiforx_READ;
    logic       i_fifotx_FULL;
    logic       o_fifotx_WRITE;
    logic [7:0] o_fifotx_WRITEDATA;
    logic [7:0] o_alu_A;
    logic [7:0] o_alu_B;
    logic [5:0] o_alu_OP;
    logic [7:0] i_alu_RESULT;
    logic       o_busy;
    logic [7:0] o_opcount;
    logic [2:0] o_state;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int pop_cyc[3];
    int rd_idx      = 0;
    int op_pop_cyc  = 0;
    int exp_count   = 0;
    bit cnt_pending = 1'b0;
    bit stalled     = 1'b0;

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6), .NB_COUNT(8)) dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_fiforx_EMPTY     (i_fiforx_EMPTY),
        .i_fiforx_READDATA  (i_fiforx_READDATA),
        .o_fiforx_READ      (o_fiforx_READ),
        .i_fifotx_FULL      (i_fifotx_FULL),
        .o_fifotx_WRITE     (o_fifotx_WRITE),
        .o_fifotx_WRITEDATA (o_fifotx_WRITEDATA),
        .o_alu_A            (o_alu_A),
        .o_alu_B            (o_alu_B),
        .o_alu_OP           (o_alu_OP),
        .i_alu_RESULT       (i_alu_RESULT),
        .o_busy             (o_busy),
        .o_opcount          (o_opcount),
        .o_state            (o_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub ALU: ADD = 0x20, SUB = 0x22
    always_comb begin
        i_alu_RESULT = 8'h00;
        case (o_alu_OP)
            6'h20: i_alu_RESULT = o_alu_A + o_alu_B;
            6'h22: i_alu_RESULT = o_alu_A - o_alu_B;
            default: i_alu_RESULT = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: the result byte a command stream must produce
    function automatic logic [7:0] ref_result(input int a, input int b, input int opbyte);
        int op;
        op = opbyte % 64;
        if (op == 32) return 8'((a + b) % 256);
        if (op == 34) return 8'((a - b + 256) % 256);
        return 8'h00;
    endfunction

    task automatic send_cmd(input int a, input int b, input int opbyte);
        rx_q.push_back(8'(a));
        rx_q.push_back(8'(b));
        rx_q.push_back(8'(opbyte));
        exp_q.push_back(ref_result(a, b, opbyte));
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #3;
            if (rx_q.size() == 0 && exp_q.size() == 0 && !o_busy) done = 1'b1;
        end
        check("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic wait_rx_level(input int level, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #3;
            if (rx_q.size() == level) done = 1'b1;
        end
        check("rx_level_reached", 32'(done), 32'd1);
    endtask

    // RX FIFO driver: first-word-fall-through view of rx_q
    initial begin
        i_fiforx_EMPTY    = 1'b1;
        i_fiforx_READDATA = 8'h00;
        forever begin
            @(negedge clk);
            i_fiforx_EMPTY    = (rx_q.size() == 0);
            i_fiforx_READDATA = i_fiforx_EMPTY ? 8'h00 : rx_q[0];
            #2;
            if (i_reset) begin
                if (!i_fiforx_EMPTY) check("rd_in_reset", 32'(o_fiforx_READ), 32'd0);
                rd_idx = 0;
            end else if (i_fiforx_EMPTY) begin
                check("rd_when_empty", 32'(o_fiforx_READ), 32'd0);
            end else if (o_fiforx_READ) begin
                void'(rx_q.pop_front());
                pop_cyc[rd_idx] = cyc;
                if (rd_idx == 2) op_pop_cyc = cyc;
                rd_idx = (rd_idx + 1) % 3;
            end
        end
    end

    // Monitor / scoreboard on the TX side
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            #2;
            if (i_reset) begin
                check("wr_in_reset", 32'(o_fifotx_WRITE), 32'd0);
                exp_count   = 0;
                cnt_pending = 1'b0;
                stalled     = 1'b0;
            end else begin
                if (cnt_pending) begin
                    check("opcount", 32'(o_opcount), 32'(exp_count));
                    cnt_pending = 1'b0;
                end
                if (i_fifotx_FULL) begin
                    stalled = 1'b1;
                    check("wr_when_full", 32'(o_fifotx_WRITE), 32'd0);
                end else if (o_fifotx_WRITE) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_write: data 0x%0h with nothing expected (cycle %0d)",
                                 o_fifotx_WRITEDATA, cyc);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("result", 32'(o_fifotx_WRITEDATA), 32'(exp_b));
                    end
                    if (!stalled) check("latency", 32'(cyc - op_pop_cyc), 32'd2);
                    stalled     = 1'b0;
                    exp_count   = (exp_count + 1) % 256;
                    cnt_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset       = 1'b1;
        i_fifotx_FULL = 1'b0;

        // Reset state; RX preloaded so reads must stay masked by reset
        send_cmd(8'h05, 8'h03, 8'h20);
        repeat (3) @(negedge clk);
        #3;
        check("rst_alu_A", 32'(o_alu_A), 32'd0);
        check("rst_alu_B", 32'(o_alu_B), 32'd0);
        check("rst_alu_OP", 32'(o_alu_OP), 32'd0);
        check("rst_wdata", 32'(o_fifotx_WRITEDATA), 32'd0);
        check("rst_opcount", 32'(o_opcount), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;

        // Pre-filled command: 5 + 3
        wait_idle(50);
        check("t1_pop_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
        check("t1_pop_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
        check("t1_alu_A", 32'(o_alu_A), 32'h05);
        check("t1_alu_B", 32'(o_alu_B), 32'h03);
        check("t1_alu_OP", 32'(o_alu_OP), 32'h20);
        check("t1_opcount", 32'(o_opcount), 32'd1);
        check("t1_busy", 32'(o_busy), 32'd0);

        // Bytes trickling in with idle gaps: 0x0A - 0x0F wraps to 0xFB
        @(negedge clk);
        exp_q.push_back(ref_result(8'h0A, 8'h0F, 8'h22));
        rx_q.push_back(8'h0A);
        repeat (20) @(negedge clk);
        rx_q.push_back(8'h0F);
        repeat (20) @(negedge clk);
        rx_q.push_back(8'h22);
        wait_idle(50);
        check("t2_alu_A", 32'(o_alu_A), 32'h0A);
        check("t2_alu_B", 32'(o_alu_B), 32'h0F);

        // TX back-pressure with a fourth byte queued behind the command
        @(negedge clk);
        i_fifotx_FULL = 1'b1;
        send_cmd(8'h01, 8'h01, 8'h20);
        rx_q.push_back(8'h07);
        wait_rx_level(1, 40);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            check("full_wdata", 32'(o_fifotx_WRITEDATA), 32'h02);
            check("full_busy", 32'(o_busy), 32'd1);
            check("full_rx_held", 32'(rx_q.size()), 32'd1);
        end
        @(negedge clk);
        i_fifotx_FULL = 1'b0;
        #3;
        check("full_release_wr", 32'(o_fifotx_WRITE), 32'd1);
        exp_q.push_back(ref_result(8'h07, 8'h02, 8'h22));
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h22);
        wait_idle(50);

        // Opcode upper bits dropped
        @(negedge clk);
        send_cmd(8'h11, 8'h22, 8'hE0);
        wait_idle(50);
        check("op_trunc", 32'(o_alu_OP), 32'h20);

        // Reset while waiting for the opcode
        @(negedge clk);
        rx_q.push_back(8'h33);
        rx_q.push_back(8'h44);
        wait_rx_level(0, 20);
        @(negedge clk);
        #3;
        check("mid_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        #3;
        check("mid_rst_A", 32'(o_alu_A), 32'd0);
        check("mid_rst_B", 32'(o_alu_B), 32'd0);
        check("mid_rst_OP", 32'(o_alu_OP), 32'd0);
        check("mid_rst_wdata", 32'(o_fifotx_WRITEDATA), 32'd0);
        check("mid_rst_opcount", 32'(o_opcount), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        send_cmd(8'h09, 8'h04, 8'h22);
        wait_idle(50);
        check("fresh_A", 32'(o_alu_A), 32'h09);
        check("fresh_B", 32'(o_alu_B), 32'h04);
        check("fresh_OP", 32'(o_alu_OP), 32'h22);
        check("fresh_opcount", 32'(o_opcount), 32'd1);

        // 256 random back-to-back commands from reset: counter wraps to 0
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            send_cmd($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 3) * 64 + ($urandom_range(0, 1) ? 34 : 32));
        end
        wait_idle(256 * 8);
        check("wrap_opcount", 32'(o_opcount), 32'd0);
        check("wrap_busy", 32'(o_busy), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
